// File: rtl/key_debounce_repeat.sv
// Multi-channel key conditioner: per-key synchroniser and counter debouncer with
// registered press/release pulses, plus a shared typematic repeat engine for the latest key.
module key_debounce_repeat #(
    parameter int n_keys         = 4,
    parameter int debounce_depth = 4,
    parameter int repeat_delay   = 25_000_000,
    parameter int repeat_period  = 5_000_000,
    parameter bit key_active_low = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [n_keys-1:0] key,
    input  logic              repeat_enable,
    output logic [n_keys-1:0] level,
    output logic [n_keys-1:0] pressed,
    output logic [n_keys-1:0] released,
    output logic [n_keys-1:0] repeat_pulse,
    output logic [n_keys-1:0] key_event,
    output logic              any_key
);

    localparam int TMAX = (repeat_delay > repeat_period) ? repeat_delay : repeat_period;
    localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 1;
    localparam int IW   = (n_keys > 1) ? $clog2(n_keys) : 1;
    localparam logic [TW-1:0] DELAY_LOAD  = TW'(repeat_delay - 1);
    localparam logic [TW-1:0] PERIOD_LOAD = TW'(repeat_period - 1);
    localparam logic [n_keys-1:0] INACTIVE = {n_keys{key_active_low}};
    localparam logic [debounce_depth-1:0] CNT_TOP = '1;

    // state  | meaning
    // IDLE   | no key being repeated
    // DELAY  | key held, waiting out the initial typematic delay
    // REPEAT | key held, pulsing every repeat_period cycles
    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    logic [n_keys-1:0]         sync1, sync2;
    logic [n_keys-1:0]         mismatch, toggle, level_nxt, press_now;
    logic [debounce_depth-1:0] cnt [n_keys];
    logic [n_keys-1:0]         rpt_q;
    logic [IW-1:0]             idx;
    logic [TW-1:0]             timer;
    state_t                    state;

    function automatic logic [IW-1:0] top_index(input logic [n_keys-1:0] v);
        top_index = '0;
        for (int i = 0; i < n_keys; i++)
            if (v[i]) top_index = IW'(i);
    endfunction

    always_comb begin
        mismatch = (sync2 ^ INACTIVE) ^ level;
        toggle   = '0;
        for (int i = 0; i < n_keys; i++)
            toggle[i] = mismatch[i] && (cnt[i] == CNT_TOP);
        level_nxt = level ^ toggle;
        press_now = toggle & ~level;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1    <= INACTIVE;
            sync2    <= INACTIVE;
            level    <= '0;
            pressed  <= '0;
            released <= '0;
            for (int i = 0; i < n_keys; i++) cnt[i] <= '0;
        end else begin
            sync1    <= key;
            sync2    <= sync1;
            level    <= level_nxt;
            pressed  <= press_now;
            released <= toggle & level;
            for (int i = 0; i < n_keys; i++) begin
                if (!mismatch[i] || toggle[i]) cnt[i] <= '0;
                else                           cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    // Timer counts down to zero; the FSM reacts to the press in the same cycle the pulse is registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            timer <= '0;
            rpt_q <= '0;
        end else begin
            rpt_q <= '0;
            if (!repeat_enable) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (|press_now) begin
                            idx   <= top_index(press_now);
                            timer <= DELAY_LOAD;
                            state <= DELAY;
                        end
                    end
                    DELAY, REPEAT: begin
                        if (|press_now) begin
                            idx   <= top_index(press_now);
                            timer <= DELAY_LOAD;
                            state <= DELAY;
                        end else if (!level_nxt[idx]) begin
                            state <= IDLE;
                        end else if (timer == '0) begin
                            rpt_q[idx] <= 1'b1;
                            timer      <= PERIOD_LOAD;
                            state      <= REPEAT;
                        end else begin
                            timer <= timer - 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign repeat_pulse = rpt_q & {n_keys{repeat_enable}};
    assign key_event    = pressed | repeat_pulse;
    assign any_key      = |level;

endmodule
